dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data-memory controller that replaces the fixed single-cycle data memory behind the CPU load/store port. It adds a ready handshake, configurable wait states, byte-lane write strobes, and error responses for misaligned or out-of-range accesses. It sits between the cpu mem_* port and an internal word-organised storage array.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, power of two.
ADDR_WIDTH, 32, byte-address width.
DEPTH_WORDS, 256, number of storage words.
WAIT_STATES, 0, extra cycles between acceptance and response (0..15).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mem_read  in  1  load request
mem_write  in  1  store request
mem_addr  in  ADDR_WIDTH  byte address
mem_wdata  in  DATA_WIDTH  store data
mem_wstrb  in  DATA_WIDTH/8  byte-lane write enables, bit i -> wdata[8i+7:8i]
mem_ready  out  1  one-cycle response strobe
mem_rdata  out  DATA_WIDTH  load data, valid when mem_ready=1
mem_err  out  1  error flag, valid when mem_ready=1
perf_rd_cnt  out  32  accepted-load count (optional feature)
perf_wr_cnt  out  32  accepted-store count (optional feature)
perf_err_cnt  out  32  error-response count (optional feature)

Behaviour:
- Reset: state=IDLE, mem_ready=0, mem_rdata=0, mem_err=0, perf counters=0. Storage contents are not cleared by reset.
- OFFS = log2(DATA_WIDTH/8). Word index = mem_addr[ADDR_WIDTH-1:OFFS].
- FSM states: IDLE, WAIT, RESP.
- IDLE: if mem_read|mem_write, latch addr/wdata/wstrb/kind. Go to WAIT if WAIT_STATES>0, else to RESP. Wait counter loads WAIT_STATES-1.
- WAIT: decrement counter each cycle; at 0 go to RESP.
- RESP: mem_ready=1 for exactly one cycle, then IDLE. Request inputs are ignored outside IDLE.
- Latency: mem_ready is asserted WAIT_STATES+1 cycles after the acceptance edge. Back-to-back throughput is one access per WAIT_STATES+2 cycles (one IDLE bubble).
- Error conditions, checked at acceptance: mem_read and mem_write both 1; mem_addr[OFFS-1:0]!=0 (misaligned); word index >= DEPTH_WORDS.
- On error: RESP with mem_err=1, mem_rdata=0, no storage write, same latency as a normal access.
- Store: on the clock edge entering RESP, write only the lanes whose strobe is 1. wstrb=0 performs no write and still completes normally (mem_err=0).
- Load: mem_rdata is registered on the edge entering RESP from the storage word at the latched index. mem_rdata holds its value after RESP until the next load or error response. mem_err clears to 0 in the cycle after RESP.
- Store response: mem_rdata unchanged, mem_err=0.
- Reset mid-operation (WAIT or RESP) aborts the access: a pending store is discarded if reset is sampled before the RESP-entry edge, and mem_ready stays 0.
- Storage read and write use the latched index, so input changes after acceptance have no effect.

Optional Feature:
Macro DMEM_PERF_CNT_EN.
- Defined: perf_rd_cnt, perf_wr_cnt and perf_err_cnt each increment by 1 on the RESP cycle of a successful load, a successful store, or an error response, respectively. Counters wrap modulo 2^32 and clear on rst.
- Undefined: no counter registers exist; the three perf ports are tied to 0. Port list is identical either way.

Test Plan:
1. WAIT_STATES=0: store addr 0x0 data 0x00000008 wstrb 0xF, then load 0x0 -> mem_ready 1 cycle after each acceptance; load returns 0x00000008, mem_err=0.
2. WAIT_STATES=3: store 0x4 data 0x11223344 wstrb 0b0101, with prior contents 0xAABBCCDD -> ready 4 cycles after acceptance; subsequent load of 0x4 returns 0xAA22CC44.
3. Load addr 0x2 (misaligned), load addr 4*DEPTH_WORDS (out of range), and read+write asserted together -> each gives mem_ready with mem_err=1 and mem_rdata=0; a re-read of word 0 is unchanged.
4. Assert rst during WAIT of a store to 0x8 data 0xDEADBEEF (WAIT_STATES=2) -> no mem_ready, outputs return to 0, and a later load of 0x8 returns the old value.
5. Back-to-back loads held high continuously, WAIT_STATES=1 -> mem_ready pulses every 3 cycles, each exactly one cycle wide.
6. With DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> perf_rd_cnt=3, perf_wr_cnt=2, perf_err_cnt=1. Without the macro, all three read 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: ready handshake, WAIT_STATES latency, byte-lane strobes, error responses.
// Optional performance counters are built when DMEM_PERF_CNT_EN is defined.
module dmem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_err,
  output logic [31:0]             perf_rd_cnt,
  output logic [31:0]             perf_wr_cnt,
  output logic [31:0]             perf_err_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [MEM_AW-1:0]       r_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic                    r_wr;
  logic                    r_bad;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic                    w_req;
  logic                    w_idle;
  logic [IDX_W-1:0]        w_in_idx;
  logic                    w_in_oor;
  logic                    w_in_err;
  logic [MEM_AW-1:0]       w_cur_idx;
  logic [DATA_WIDTH-1:0]   w_cur_wdata;
  logic [STRB_W-1:0]       w_cur_wstrb;
  logic                    w_cur_wr;
  logic                    w_cur_err;
  logic                    w_enter_resp;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_req    = mem_read | mem_write;
  assign w_idle   = (r_state == S_IDLE);
  assign w_in_idx = mem_addr[ADDR_WIDTH-1:OFFS];
  assign w_in_oor = ({{(64-IDX_W){1'b0}}, w_in_idx} >= 64'(DEPTH_WORDS));
  assign w_in_err = (mem_read & mem_write) | (|(mem_addr & LOW_MASK)) | w_in_oor;

  // With zero wait states the acceptance edge is also the RESP-entry edge, so take the live inputs.
  assign w_cur_idx   = w_idle ? w_in_idx[MEM_AW-1:0] : r_idx;
  assign w_cur_wdata = w_idle ? mem_wdata : r_wdata;
  assign w_cur_wstrb = w_idle ? mem_wstrb : r_wstrb;
  assign w_cur_wr    = w_idle ? mem_write : r_wr;
  assign w_cur_err   = w_idle ? w_in_err  : r_bad;

  assign w_enter_resp = (w_idle && w_req && (WAIT_STATES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_old = r_mem[w_cur_idx];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < STRB_W; i++) begin
      if (w_cur_wstrb[i]) w_merged[8*i +: 8] = w_cur_wdata[8*i +: 8];
    end
  end

  // Storage is deliberately not reset; a reset sampled on the entry edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_cur_wr && !w_cur_err) begin
      r_mem[w_cur_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= w_in_idx[MEM_AW-1:0];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_wr    <= mem_write;
            r_bad   <= w_in_err;
            r_cnt   <= 4'(WAIT_STATES - 1);
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
      endcase
      if (w_enter_resp) begin
        r_ready <= 1'b1;
        r_err   <= w_cur_err;
        if (w_cur_err)      r_rdata <= '0;
        else if (!w_cur_wr) r_rdata <= w_old;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign mem_err   = r_err;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_perf_rd;
  logic [31:0] r_perf_wr;
  logic [31:0] r_perf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_rd  <= 32'd0;
      r_perf_wr  <= 32'd0;
      r_perf_err <= 32'd0;
    end else if (r_state == S_RESP) begin
      if (r_err)     r_perf_err <= r_perf_err + 32'd1;
      else if (r_wr) r_perf_wr  <= r_perf_wr + 32'd1;
      else           r_perf_rd  <= r_perf_rd + 32'd1;
    end
  end

  assign perf_rd_cnt  = r_perf_rd;
  assign perf_wr_cnt  = r_perf_wr;
  assign perf_err_cnt = r_perf_err;
`else
  assign perf_rd_cnt  = 32'd0;
  assign perf_wr_cnt  = 32'd0;
  assign perf_err_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: four instances with WAIT_STATES = 0..3 (instance index = wait states).
// Handshake: a request is held until the acceptance edge; mem_ready is a one-cycle response strobe.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        rd    [4];
  logic        wr    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  wstrb [4];
  logic        ready [4];
  logic [31:0] rdata [4];
  logic        err   [4];
  logic [31:0] p_rd  [4];
  logic [31:0] p_wr  [4];
  logic [31:0] p_err [4];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(g)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .mem_read(rd[g]), .mem_write(wr[g]), .mem_addr(addr[g]),
      .mem_wdata(wdata[g]), .mem_wstrb(wstrb[g]),
      .mem_ready(ready[g]), .mem_rdata(rdata[g]), .mem_err(err[g]),
      .perf_rd_cnt(p_rd[g]), .perf_wr_cnt(p_wr[g]), .perf_err_cnt(p_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, releases it after the acceptance edge, then waits (bounded) for mem_ready.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] o_rdata, output logic o_err, output int lat);
    @(posedge clk); #1;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    lat = 1;
    while (!ready[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    o_rdata = rdata[d];
    o_err   = err[d];
  endtask

  initial begin
    logic [31:0] od;
    logic        oe;
    int          lat;
    int          seen;
    logic [31:0] pattern;
    logic [31:0] exp_rd, exp_wr, exp_err;

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_ready", 32'(ready[i]), 32'd0);
      check("reset_rdata", rdata[i], 32'd0);
      check("reset_err",   32'(err[i]), 32'd0);
      check("reset_perf",  p_rd[i] | p_wr[i] | p_err[i], 32'd0);
      rst[i] = 1'b0;
    end

    // WAIT_STATES=0: store then load word 0
    access(0, 1'b0, 1'b1, 32'h0, 32'h0000_0008, 4'hF, od, oe, lat);
    check("ws0_store_lat", 32'(lat), 32'd1);
    check("ws0_store_err", 32'(oe), 32'd0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, od, oe, lat);
    check("ws0_load_lat", 32'(lat), 32'd1);
    check("ws0_load_data", od, 32'h0000_0008);
    check("ws0_load_err", 32'(oe), 32'd0);
    @(posedge clk); #1;
    check("ws0_ready_width", 32'(ready[0]), 32'd0);
    check("ws0_rdata_hold", rdata[0], 32'h0000_0008);

    // Error responses on WAIT_STATES=0
    access(0, 1'b1, 1'b0, 32'h2, 32'h0, 4'h0, od, oe, lat);
    check("misaligned_lat", 32'(lat), 32'd1);
    check("misaligned_err", 32'(oe), 32'd1);
    check("misaligned_rdata", od, 32'd0);
    @(posedge clk); #1;
    check("err_clears", 32'(err[0]), 32'd0);
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, od, oe, lat);
    check("oor_err", 32'(oe), 32'd1);
    check("oor_rdata", od, 32'd0);
    access(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, od, oe, lat);
    check("rdwr_err", 32'(oe), 32'd1);
    check("rdwr_rdata", od, 32'd0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, od, oe, lat);
    check("word0_unchanged", od, 32'h0000_0008);
    check("word0_err", 32'(oe), 32'd0);

    // WAIT_STATES=3: partial-strobe store
    access(3, 1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, od, oe, lat);
    check("ws3_store_lat", 32'(lat), 32'd4);
    access(3, 1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, od, oe, lat);
    check("ws3_strb_lat", 32'(lat), 32'd4);
    check("ws3_strb_err", 32'(oe), 32'd0);
    access(3, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, od, oe, lat);
    check("ws3_load_lat", 32'(lat), 32'd4);
    check("ws3_merged", od, 32'hAA22_CC44);
    access(3, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, od, oe, lat);
    check("ws3_reload", od, 32'hAA22_CC44);
    access(3, 1'b1, 1'b0, 32'h5, 32'h0, 4'h0, od, oe, lat);
    check("ws3_err_lat", 32'(lat), 32'd4);
    check("ws3_err", 32'(oe), 32'd1);
    access(3, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, od, oe, lat);
    check("ws3_after_err", od, 32'hAA22_CC44);
    @(posedge clk); #1;
    `ifdef DMEM_PERF_CNT_EN
    exp_rd = 32'd3; exp_wr = 32'd2; exp_err = 32'd1;
    `else
    exp_rd = 32'd0; exp_wr = 32'd0; exp_err = 32'd0;
    `endif
    check("perf_rd", p_rd[3], exp_rd);
    check("perf_wr", p_wr[3], exp_wr);
    check("perf_err", p_err[3], exp_err);

    // WAIT_STATES=2: reset during WAIT of a store aborts it
    access(2, 1'b0, 1'b1, 32'h8, 32'h1234_5678, 4'hF, od, oe, lat);
    check("ws2_store_lat", 32'(lat), 32'd3);
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, od, oe, lat);
    check("ws2_load", od, 32'h1234_5678);
    access(2, 1'b0, 1'b1, 32'hC, 32'h0BAD_F00D, 4'hF, od, oe, lat);
    check("store_keeps_rdata", od, 32'h1234_5678);
    check("store_err", 32'(oe), 32'd0);
    @(posedge clk); #1;
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'hDEAD_BEEF; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    wr[2] = 1'b0;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready[2]), 32'd0);
    check("abort_rdata", rdata[2], 32'd0);
    check("abort_err", 32'(err[2]), 32'd0);
    rst[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen += int'(ready[2]);
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, od, oe, lat);
    check("abort_old_value", od, 32'h1234_5678);

    // WAIT_STATES=1: loads held high back to back
    access(1, 1'b0, 1'b1, 32'h0, 32'h5A5A_5A5A, 4'hF, od, oe, lat);
    check("ws1_store_lat", 32'(lat), 32'd2);
    @(posedge clk); #1;
    rd[1] = 1'b1; addr[1] = 32'h0;
    pattern = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      pattern[i] = ready[1];
    end
    rd[1] = 1'b0;
    check("b2b_pattern", pattern, 32'h0000_0492);
    check("b2b_rdata", rdata[1], 32'h5A5A_5A5A);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
